adc_cal_sequencer: RTL
======================

Name: adc_cal_sequencer

Overview:
Digital controller that sequences the 12-bit pipeline ADC macro through power-up, calibration and recalibration. It drives the triplicated OM/CAL/DF control pins and watches the ADC's CAL_BUSY flag. It tells downstream logic when ADC data is valid and flags calibration timeouts. It sits in the DTU core between the I2C-configured control registers and the ADC hard macro.

Parameters:
BUSY_WAIT_CYC, 64, max cycles from entering active mode (or releasing CAL) until the synchronized CAL_BUSY must rise.
CAL_TIMEOUT_CYC, 32768, max cycles CAL_BUSY may stay high; must exceed 26762+12 DCLK equivalents.
CAL_PULSE_CYC, 4, cycles CAL is held high to reset the ADC before recalibration (min 2).
CNT_W, 16, width of the shared wait/timeout counter; must hold max(BUSY_WAIT_CYC, CAL_TIMEOUT_CYC).

Ports:
CLK  in  1  system clock (same domain as ADC DCLK consumer logic)
RST_N  in  1  reset, asynchronous assert, active-low
en_i  in  1  ADC enable from config register; 1 = bring ADC up, 0 = power down
recal_i  in  1  recalibration request, level-sensitive, sampled only in READY
df_cfg_i  in  1  output data format (0 binary, 1 two's complement)
cal_busy_i  in  1  ADC CAL_BUSY, asynchronous to CLK
om_o  out  3  OM_A/B/C, all bits identical
cal_o  out  3  CAL_A/B/C, all bits identical
df_o  out  3  DF_A/B/C, all bits identical
ready_o  out  1  ADC calibrated, data valid
err_o  out  1  calibration timeout, sticky until en_i low
state_o  out  3  current state encoding
cal_cnt_o  out  8  completed calibrations, saturates at 255

Behaviour:
- Reset values: state OFF, om_o=000, cal_o=000, df_o=000, ready_o=0, err_o=0, cal_cnt_o=0, counter=0, sync flops=0.
- cal_busy_i passes through a 2-flop synchronizer; "busy" below means the synchronized value. Rise/fall are detected against one extra registered copy. Minimum sampling latency is 2 CLK.
- States (state_o): OFF=0, WAIT_BUSY=1, CAL_RUN=2, READY=3, CAL_PULSE=4, ERROR=5.
- OFF: om_o=000, cal_o=000. df_o follows df_cfg_i every cycle. DF may change only here. On en_i=1, go to WAIT_BUSY, clear counter and drive om_o=111 from the next cycle.
- In every state except OFF, df_o holds its last value, so df_cfg_i changes are ignored until the next OFF.
- WAIT_BUSY: counter increments each cycle.
  - busy rise -> CAL_RUN, counter cleared.
  - counter reaches BUSY_WAIT_CYC-1 with no rise -> ERROR.
- CAL_RUN: counter increments each cycle.
  - busy fall -> READY, cal_cnt_o+1 (saturating).
  - counter reaches CAL_TIMEOUT_CYC-1 while busy -> ERROR.
- READY: ready_o=1, registered in the same cycle the state is entered.
  - recal_i=1 -> CAL_PULSE, counter cleared, ready_o=0 on the next cycle.
  - busy rises while in READY (spurious ADC recal) -> CAL_RUN, ready_o=0.
- CAL_PULSE: cal_o=111 for exactly CAL_PULSE_CYC cycles, then cal_o=000 -> WAIT_BUSY with counter cleared. The ADC recalibrates on the CAL falling edge.
- ERROR: om_o=000, cal_o=000, ready_o=0, err_o=1. Held until en_i=0, then -> OFF and err_o cleared the same cycle.
- en_i=0 in any state (highest priority, including mid-pulse and mid-cal) -> OFF next cycle.
  - om_o, cal_o and ready_o drop to 0 in that cycle.
  - err_o clears.
  - cal_cnt_o is retained; only RST_N clears it.
- Simultaneous en_i=0 and any other event: en_i wins.
- Simultaneous busy fall and timeout terminal count in CAL_RUN: the fall wins -> READY.
- Asynchronous reset mid-operation returns all outputs to reset values immediately.
- om_o, cal_o, df_o are driven from single registers fanned out ×3. No combinational path from inputs to outputs.

Test Plan:
1. RST_N low 5 cycles, then high; en_i=1 at cycle 10; cal_busy_i rises at cycle 20 and falls at cycle 120 -> om_o=111 from cycle 11, state_o 1→2→3, ready_o=1 about 3 cycles after the fall, cal_cnt_o=1.
2. BUSY_WAIT_CYC=64; en_i=1 with cal_busy_i held 0 -> state_o=5, err_o=1, om_o=000 after 64 cycles in WAIT_BUSY; drop en_i -> state 0, err_o=0 next cycle.
3. CAL_TIMEOUT_CYC=200 (override); busy held high -> ERROR after exactly 200 cycles in CAL_RUN; ready_o never asserts.
4. From READY, pulse recal_i 1 cycle -> cal_o=111 for 4 cycles, then WAIT_BUSY; busy rise/fall again -> READY, cal_cnt_o=2.
5. Toggle df_cfg_i 0→1 while READY -> df_o stays 000; en_i=0 -> OFF, df_o=111 on the following cycle.
6. Deassert en_i during CAL_PULSE cycle 2 -> cal_o=000, om_o=000, state_o=0 next cycle, cal_cnt_o unchanged.

Source files
------------

// File: rtl/adc_cal_sequencer.sv
// ADC power-up/calibration sequencer: drives triplicated OM/CAL/DF, tracks CAL_BUSY, flags timeouts.
// All outputs registered; CAL_BUSY seen after a 2-flop synchronizer, so busy edges act 3 cycles after the pin.
module adc_cal_sequencer #(
  parameter int BUSY_WAIT_CYC   = 64,
  parameter int CAL_TIMEOUT_CYC = 32768,
  parameter int CAL_PULSE_CYC   = 4,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en_i,
  input  logic       recal_i,
  input  logic       df_cfg_i,
  input  logic       cal_busy_i,
  output logic [2:0] om_o,
  output logic [2:0] cal_o,
  output logic [2:0] df_o,
  output logic       ready_o,
  output logic       err_o,
  output logic [2:0] state_o,
  output logic [7:0] cal_cnt_o
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WAIT_BUSY = 3'd1,
    S_CAL_RUN   = 3'd2,
    S_READY     = 3'd3,
    S_CAL_PULSE = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] BUSY_TC  = CNT_W'(BUSY_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CAL_TC   = CNT_W'(CAL_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(CAL_PULSE_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_s1, busy_s2, busy_d;
  logic             busy_rise, busy_fall;
  logic             cal_done;
  logic             om_r, cal_r, df_r, ready_r, err_r;
  logic [7:0]       cal_cnt;

  assign busy_rise = busy_s2 & ~busy_d;
  assign busy_fall = ~busy_s2 & busy_d;

  always_comb begin
    state_nxt = state;
    cal_done  = 1'b0;
    if (!en_i) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:       state_nxt = S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (busy_rise)           state_nxt = S_CAL_RUN;
          else if (cnt == BUSY_TC) state_nxt = S_ERROR;
        end
        S_CAL_RUN: begin
          // A fall on the terminal-count cycle still counts as a good calibration.
          if (busy_fall) begin
            state_nxt = S_READY;
            cal_done  = 1'b1;
          end else if (busy_s2 && cnt == CAL_TC) begin
            state_nxt = S_ERROR;
          end
        end
        S_READY: begin
          if (busy_rise)    state_nxt = S_CAL_RUN;
          else if (recal_i) state_nxt = S_CAL_PULSE;
        end
        S_CAL_PULSE: if (cnt == PULSE_TC) state_nxt = S_WAIT_BUSY;
        S_ERROR:     state_nxt = S_ERROR;
        default:     state_nxt = S_OFF;
      endcase
    end
  end

  // Counter only runs while staying in a timed state; every entry starts it from zero.
  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state &&
        (state == S_WAIT_BUSY || state == S_CAL_RUN || state == S_CAL_PULSE))
      cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_OFF;
      cnt     <= '0;
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      busy_d  <= 1'b0;
      om_r    <= 1'b0;
      cal_r   <= 1'b0;
      df_r    <= 1'b0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      cal_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy_s1 <= cal_busy_i;
      busy_s2 <= busy_s1;
      busy_d  <= busy_s2;
      om_r    <= (state_nxt != S_OFF) && (state_nxt != S_ERROR);
      cal_r   <= (state_nxt == S_CAL_PULSE);
      ready_r <= (state_nxt == S_READY);
      err_r   <= (state_nxt == S_ERROR);
      if (state == S_OFF)
        df_r <= df_cfg_i;
      if (cal_done && cal_cnt != 8'hFF)
        cal_cnt <= cal_cnt + 8'd1;
    end
  end

  assign om_o      = {3{om_r}};
  assign cal_o     = {3{cal_r}};
  assign df_o      = {3{df_r}};
  assign ready_o   = ready_r;
  assign err_o     = err_r;
  assign state_o   = state;
  assign cal_cnt_o = cal_cnt;

endmodule
